mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Merges the instruction-side and data-side cache read ports onto one shared
// memory bus read channel, and buffers a single data-side write on the bus
// write channel.
//
// Read path : one read outstanding at a time. I and D requests are arbitrated
//             with a 1-bit round-robin pointer. Return beats are steered to the
//             owner of the outstanding read.
// Write path: one-entry write buffer, independent of the read path. A D-side
//             read to the same cache line as the buffered write is held off
//             until the write has completed on the bus.
//
// Ports
//   aclk, aresetn                  clock, asynchronous active-low reset
//   i_rd_req/type/addr, i_rd_rdy   I-side read request / accepted
//   d_rd_req/type/addr, d_rd_rdy   D-side read request / accepted
//   i_ret_valid, d_ret_valid       return beat valid for I-side / D-side
//   ret_last, ret_data             shared return beat last flag and data
//   d_wr_req/type/addr/wstrb/data  D-side write request
//   d_wr_rdy                       write buffer is free
//   bus_rd_*                       bus read request channel
//   bus_ret_*                      bus read return channel
//   bus_wr_*                       bus write request channel
//   bus_wr_rdy, bus_wr_done        bus write accepted / write completed
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int LINE_OFF = 4
) (
  input  logic         aclk,
  input  logic         aresetn,

  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,

  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,

  output logic         i_ret_valid,
  output logic         d_ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,

  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,

  output logic         bus_rd_req,
  output logic [2:0]   bus_rd_type,
  output logic [31:0]  bus_rd_addr,
  input  logic         bus_rd_rdy,

  input  logic         bus_ret_valid,
  input  logic         bus_ret_last,
  input  logic [31:0]  bus_ret_data,

  output logic         bus_wr_req,
  output logic [2:0]   bus_wr_type,
  output logic [31:0]  bus_wr_addr,
  output logic [3:0]   bus_wr_wstrb,
  output logic [127:0] bus_wr_data,
  input  logic         bus_wr_rdy,
  input  logic         bus_wr_done
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} w_state_e;

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic        owner_d_q, owner_d_d;   // owner of the outstanding read: 1 = D
  logic        prio_d_q,  prio_d_d;    // round-robin pointer: 1 = D favoured
  logic [2:0]  rd_type_q, rd_type_d;
  logic [31:0] rd_addr_q, rd_addr_d;

  // ---------------------------------------------------------------------------
  // Write buffer state
  // ---------------------------------------------------------------------------
  w_state_e     w_state_q, w_state_d;
  logic [2:0]   wr_type_q,  wr_type_d;
  logic [31:0]  wr_addr_q,  wr_addr_d;
  logic [3:0]   wr_wstrb_q, wr_wstrb_d;
  logic [127:0] wr_data_q,  wr_data_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic hazard;
  logic i_elig, d_elig;
  logic grant_i, grant_d;

  // The compare uses the registered write state, so a write being accepted on
  // the same edge as a D read grant does not block that grant.
  assign hazard = (w_state_q != W_IDLE) &&
                  (d_rd_addr[31:LINE_OFF] == wr_addr_q[31:LINE_OFF]);

  assign i_elig = i_rd_req;
  assign d_elig = d_rd_req && !hazard;

  // With both eligible the pointer decides; grant_i and grant_d are exclusive.
  assign grant_i = i_elig && (!d_elig || !prio_d_q);
  assign grant_d = d_elig && (!i_elig ||  prio_d_q);

  // ---------------------------------------------------------------------------
  // Read FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    r_state_d   = r_state_q;
    owner_d_d   = owner_d_q;
    prio_d_d    = prio_d_q;
    rd_type_d   = rd_type_q;
    rd_addr_d   = rd_addr_q;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    bus_rd_req  = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    ret_last    = 1'b0;
    ret_data    = '0;

    unique case (r_state_q)
      R_IDLE: begin
        if (grant_i) begin
          owner_d_d = 1'b0;
          prio_d_d  = 1'b1;
          rd_type_d = i_rd_type;
          rd_addr_d = i_rd_addr;
          r_state_d = R_REQ;
        end else if (grant_d) begin
          owner_d_d = 1'b1;
          prio_d_d  = 1'b0;
          rd_type_d = d_rd_type;
          rd_addr_d = d_rd_addr;
          r_state_d = R_REQ;
        end
      end

      R_REQ: begin
        bus_rd_req = 1'b1;
        i_rd_rdy   = !owner_d_q && bus_rd_rdy;
        d_rd_rdy   =  owner_d_q && bus_rd_rdy;
        if (bus_rd_rdy) begin
          r_state_d = R_RESP;
        end
      end

      R_RESP: begin
        i_ret_valid = !owner_d_q && bus_ret_valid;
        d_ret_valid =  owner_d_q && bus_ret_valid;
        ret_last    = bus_ret_last;
        ret_data    = bus_ret_data;
        if (bus_ret_valid && bus_ret_last) begin
          r_state_d = R_IDLE;
        end
      end

      default: r_state_d = R_IDLE;
    endcase
  end

  assign bus_rd_type = rd_type_q;
  assign bus_rd_addr = rd_addr_q;

  // ---------------------------------------------------------------------------
  // Write FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d  = w_state_q;
    wr_type_d  = wr_type_q;
    wr_addr_d  = wr_addr_q;
    wr_wstrb_d = wr_wstrb_q;
    wr_data_d  = wr_data_q;
    d_wr_rdy   = 1'b0;
    bus_wr_req = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        d_wr_rdy = 1'b1;
        if (d_wr_req) begin
          wr_type_d  = d_wr_type;
          wr_addr_d  = d_wr_addr;
          wr_wstrb_d = d_wr_wstrb;
          wr_data_d  = d_wr_data;
          w_state_d  = W_REQ;
        end
      end

      W_REQ: begin
        bus_wr_req = 1'b1;
        if (bus_wr_rdy) begin
          w_state_d = W_WAIT;
        end
      end

      // A new request arriving together with bus_wr_done is not accepted here;
      // it is taken the next cycle from W_IDLE.
      W_WAIT: begin
        if (bus_wr_done) begin
          w_state_d = W_IDLE;
        end
      end

      default: w_state_d = W_IDLE;
    endcase
  end

  assign bus_wr_type  = wr_type_q;
  assign bus_wr_addr  = wr_addr_q;
  assign bus_wr_wstrb = wr_wstrb_q;
  assign bus_wr_data  = wr_data_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the latched request fields are reset as well, so the bus address,
  // type, strobe and data outputs read 0 while in reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q  <= R_IDLE;
      owner_d_q  <= 1'b0;
      prio_d_q   <= 1'b0;
      rd_type_q  <= '0;
      rd_addr_q  <= '0;
      w_state_q  <= W_IDLE;
      wr_type_q  <= '0;
      wr_addr_q  <= '0;
      wr_wstrb_q <= '0;
      wr_data_q  <= '0;
    end else begin
      r_state_q  <= r_state_d;
      owner_d_q  <= owner_d_d;
      prio_d_q   <= prio_d_d;
      rd_type_q  <= rd_type_d;
      rd_addr_q  <= rd_addr_d;
      w_state_q  <= w_state_d;
      wr_type_q  <= wr_type_d;
      wr_addr_q  <= wr_addr_d;
      wr_wstrb_q <= wr_wstrb_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule
